// File: rtl/ro10_sync_seq_if.sv
// AXI4-Lite master-side bundle used by the RO10_sync sequencer.
// Signal names follow the usual M_AXI_* convention of the register bank.
interface ro10_sync_seq_if;
    logic [31:0] M_AXI_AWADDR;
    logic [2:0]  M_AXI_AWPROT;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID;
    logic        M_AXI_BREADY;
    logic [31:0] M_AXI_ARADDR;
    logic [2:0]  M_AXI_ARPROT;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RVALID;
    logic        M_AXI_RREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        input  M_AXI_RREADY
    );
endinterface

// File: rtl/ro10_sync_seq.sv
// Runs one RO10_sync measurement per start: program WINDOW, enable, poll STATUS,
// read RESULT, then always clear CTRL. Bad responses and poll timeouts pulse error.
module ro10_sync_seq #(
    parameter logic [31:0] C_BASE_ADDR  = 32'h0000_0000,
    parameter int          C_POLL_MAX   = 1024,
    parameter int          C_DATA_WIDTH = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    start,
    input  logic [C_DATA_WIDTH-1:0] window,
    output logic                    busy,
    output logic [C_DATA_WIDTH-1:0] result,
    output logic                    result_valid,
    output logic                    error,
    ro10_sync_seq_if.master         m_axi
);

    localparam logic [31:0] OFF_CTRL   = 32'h0;
    localparam logic [31:0] OFF_WINDOW = 32'h4;
    localparam logic [31:0] OFF_STATUS = 32'h8;
    localparam logic [31:0] OFF_RESULT = 32'hC;
    localparam int          CNT_W      = $clog2(C_POLL_MAX + 1);

    typedef enum logic [2:0] {IDLE, WR_WIN, WR_GO, POLL, RD_RES, WR_CLR} state_t;

    state_t                  state_q, state_d;
    logic                    issued_q, issued_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic [31:0]             addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [C_DATA_WIDTH-1:0] window_q, window_d;
    logic [CNT_W-1:0]        poll_cnt_q, poll_cnt_d;
    logic [C_DATA_WIDTH-1:0] result_q, result_d;
    logic                    result_valid_q, result_valid_d;
    logic                    error_q, error_d;

    // issued_q=0 means the current state still has to launch its transaction;
    // the launch cycle also gives the mandatory idle gap between STATUS reads.
    always_comb begin
        state_d        = state_q;
        issued_d       = issued_q;
        awvalid_d      = awvalid_q;
        wvalid_d       = wvalid_q;
        bready_d       = bready_q;
        arvalid_d      = arvalid_q;
        rready_d       = rready_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        window_d       = window_q;
        poll_cnt_d     = poll_cnt_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        error_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    window_d   = window;
                    poll_cnt_d = '0;
                    issued_d   = 1'b0;
                    state_d    = WR_WIN;
                end
            end
            WR_WIN, WR_GO, WR_CLR: begin
                if (!issued_q) begin
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    bready_d  = 1'b1;
                    issued_d  = 1'b1;
                    addr_d    = C_BASE_ADDR + ((state_q == WR_WIN) ? OFF_WINDOW : OFF_CTRL);
                    if (state_q == WR_WIN)     wdata_d = window_q;
                    else if (state_q == WR_GO) wdata_d = 32'd1;
                    else                       wdata_d = 32'd0;
                end else begin
                    if (awvalid_q && m_axi.M_AXI_AWREADY) awvalid_d = 1'b0;
                    if (wvalid_q && m_axi.M_AXI_WREADY)   wvalid_d  = 1'b0;
                    if (bready_q && m_axi.M_AXI_BVALID) begin
                        bready_d = 1'b0;
                        issued_d = 1'b0;
                        if (state_q == WR_CLR) begin
                            state_d = IDLE;
                        end else if (m_axi.M_AXI_BRESP != 2'b00) begin
                            error_d = 1'b1;
                            state_d = WR_CLR;
                        end else if (state_q == WR_WIN) begin
                            state_d = WR_GO;
                        end else begin
                            state_d = POLL;
                        end
                    end
                end
            end
            POLL, RD_RES: begin
                if (!issued_q) begin
                    arvalid_d = 1'b1;
                    issued_d  = 1'b1;
                    addr_d    = C_BASE_ADDR + ((state_q == POLL) ? OFF_STATUS : OFF_RESULT);
                end else begin
                    if (arvalid_q && m_axi.M_AXI_ARREADY) begin
                        arvalid_d = 1'b0;
                        rready_d  = 1'b1;
                    end
                    if (rready_q && m_axi.M_AXI_RVALID) begin
                        rready_d = 1'b0;
                        issued_d = 1'b0;
                        if (m_axi.M_AXI_RRESP != 2'b00) begin
                            error_d = 1'b1;
                            state_d = WR_CLR;
                        end else if (state_q == RD_RES) begin
                            result_d       = m_axi.M_AXI_RDATA;
                            result_valid_d = 1'b1;
                            state_d        = WR_CLR;
                        end else if (m_axi.M_AXI_RDATA[0]) begin
                            state_d = RD_RES;
                        end else begin
                            poll_cnt_d = poll_cnt_q + 1'b1;
                            if (poll_cnt_q == CNT_W'(C_POLL_MAX - 1)) begin
                                error_d = 1'b1;
                                state_d = WR_CLR;
                            end
                        end
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                issued_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q        <= IDLE;
            issued_q       <= 1'b0;
            awvalid_q      <= 1'b0;
            wvalid_q       <= 1'b0;
            bready_q       <= 1'b0;
            arvalid_q      <= 1'b0;
            rready_q       <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            window_q       <= '0;
            poll_cnt_q     <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            issued_q       <= issued_d;
            awvalid_q      <= awvalid_d;
            wvalid_q       <= wvalid_d;
            bready_q       <= bready_d;
            arvalid_q      <= arvalid_d;
            rready_q       <= rready_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            window_q       <= window_d;
            poll_cnt_q     <= poll_cnt_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            error_q        <= error_d;
        end
    end

    // Only one transaction is ever outstanding, so AW and AR share one address register.
    assign m_axi.M_AXI_AWADDR  = addr_q;
    assign m_axi.M_AXI_AWPROT  = 3'b000;
    assign m_axi.M_AXI_AWVALID = awvalid_q;
    assign m_axi.M_AXI_WDATA   = wdata_q;
    assign m_axi.M_AXI_WSTRB   = 4'hF;
    assign m_axi.M_AXI_WVALID  = wvalid_q;
    assign m_axi.M_AXI_BREADY  = bready_q;
    assign m_axi.M_AXI_ARADDR  = addr_q;
    assign m_axi.M_AXI_ARPROT  = 3'b000;
    assign m_axi.M_AXI_ARVALID = arvalid_q;
    assign m_axi.M_AXI_RREADY  = rready_q;

    assign busy         = (state_q != IDLE);
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign error        = error_q;

endmodule

// File: tb/tb_ro10_sync_seq.sv
// Scoreboard bench for ro10_sync_seq: a register-bank slave model answers the AXI
// traffic, the main process queues expected events, a monitor pops and compares.
module tb_ro10_sync_seq;

    localparam logic [31:0] BASE = 32'h4000_1000;
    localparam int EV_WR  = 0;
    localparam int EV_RD  = 1;
    localparam int EV_RES = 2;
    localparam int EV_ERR = 3;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        start = 1'b0;
    logic [31:0] window = 32'h0;
    logic        busy;
    logic [31:0] result;
    logic        result_valid;
    logic        error;

    ro10_sync_seq_if axi ();

    ro10_sync_seq #(
        .C_BASE_ADDR (BASE),
        .C_POLL_MAX  (4),
        .C_DATA_WIDTH(32)
    ) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .start       (start),
        .window      (window),
        .busy        (busy),
        .result      (result),
        .result_valid(result_valid),
        .error       (error),
        .m_axi       (axi)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    // slave configuration, written only by the main process
    int          aw_delay      = 0;
    int          w_delay       = 0;
    bit          stall         = 1'b0;
    int          done_after    = 3;
    logic [31:0] res_val       = 32'hDEAD_BEEF;
    logic [31:0] bresp_err_adr = 32'hFFFF_FFFF;

    function automatic string kname(input int k);
        case (k)
            EV_WR:   return "WR";
            EV_RD:   return "RD";
            EV_RES:  return "RES";
            default: return "ERR";
        endcase
    endfunction

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endfunction

    function automatic void push_ev(input int k, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endfunction

    function automatic void got_ev(input int k, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got %s addr=%h data=%h, expected none", kname(k), a, d);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != k || e.addr !== a || e.data !== d) begin
            n_bad++;
            $display("FAIL event: got %s addr=%h data=%h, expected %s addr=%h data=%h",
                     kname(k), a, d, kname(e.kind), e.addr, e.data);
        end else begin
            $display("event ok: %s addr=%h data=%h", kname(k), a, d);
        end
    endfunction

    // ---------------- slave register-bank model ----------------
    initial begin
        bit s_rst, s_aw, s_w, s_b, s_ar, s_r;
        logic [31:0] s_awaddr, s_wdata, s_araddr, wr_addr, wr_data, rd_addr;
        bit have_aw, have_w, have_ar;
        int aw_wait, w_wait, status_reads;
        have_aw = 0; have_w = 0; have_ar = 0;
        aw_wait = 0; w_wait = 0; status_reads = 0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;
        axi.M_AXI_AWREADY = 1'b0;
        axi.M_AXI_WREADY  = 1'b0;
        axi.M_AXI_BVALID  = 1'b0;
        axi.M_AXI_BRESP   = 2'b00;
        axi.M_AXI_ARREADY = 1'b0;
        axi.M_AXI_RVALID  = 1'b0;
        axi.M_AXI_RDATA   = '0;
        axi.M_AXI_RRESP   = 2'b00;
        forever begin
            @(negedge ACLK);
            s_rst    = ARESET;
            s_aw     = axi.M_AXI_AWVALID && axi.M_AXI_AWREADY;
            s_awaddr = axi.M_AXI_AWADDR;
            s_w      = axi.M_AXI_WVALID && axi.M_AXI_WREADY;
            s_wdata  = axi.M_AXI_WDATA;
            s_b      = axi.M_AXI_BVALID && axi.M_AXI_BREADY;
            s_ar     = axi.M_AXI_ARVALID && axi.M_AXI_ARREADY;
            s_araddr = axi.M_AXI_ARADDR;
            s_r      = axi.M_AXI_RVALID && axi.M_AXI_RREADY;
            @(posedge ACLK);
            #1;
            if (s_rst) begin
                have_aw = 0; have_w = 0; have_ar = 0; aw_wait = 0; w_wait = 0;
                axi.M_AXI_AWREADY = 1'b0;
                axi.M_AXI_WREADY  = 1'b0;
                axi.M_AXI_BVALID  = 1'b0;
                axi.M_AXI_ARREADY = 1'b0;
                axi.M_AXI_RVALID  = 1'b0;
            end else begin
                if (s_aw) begin
                    have_aw = 1; wr_addr = s_awaddr; axi.M_AXI_AWREADY = 1'b0; aw_wait = 0;
                end else if (axi.M_AXI_AWVALID && !have_aw) begin
                    if (aw_wait >= aw_delay) axi.M_AXI_AWREADY = 1'b1;
                    else aw_wait++;
                end
                if (s_w) begin
                    have_w = 1; wr_data = s_wdata; axi.M_AXI_WREADY = 1'b0; w_wait = 0;
                end else if (axi.M_AXI_WVALID && !have_w) begin
                    if (w_wait >= w_delay) axi.M_AXI_WREADY = 1'b1;
                    else w_wait++;
                end
                if (s_b) begin
                    axi.M_AXI_BVALID = 1'b0;
                end else if (have_aw && have_w && !axi.M_AXI_BVALID) begin
                    axi.M_AXI_BVALID = 1'b1;
                    axi.M_AXI_BRESP  = (wr_addr == bresp_err_adr) ? 2'b10 : 2'b00;
                    if (wr_addr == BASE && wr_data == 32'd1) status_reads = 0;
                    have_aw = 0; have_w = 0;
                end
                if (s_r) begin
                    axi.M_AXI_RVALID = 1'b0; have_ar = 0;
                end else if (s_ar) begin
                    have_ar = 1; rd_addr = s_araddr; axi.M_AXI_ARREADY = 1'b0;
                end else if (axi.M_AXI_ARVALID && !have_ar) begin
                    axi.M_AXI_ARREADY = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (have_ar && !axi.M_AXI_RVALID && !s_ar &&
                    !(stall && $urandom_range(0, 1) == 0)) begin
                    axi.M_AXI_RVALID = 1'b1;
                    axi.M_AXI_RRESP  = 2'b00;
                    if (rd_addr == BASE + 32'h8) begin
                        status_reads++;
                        axi.M_AXI_RDATA = (done_after != 0 && status_reads >= done_after) ? 32'd1 : 32'd0;
                    end else if (rd_addr == BASE + 32'hC) begin
                        axi.M_AXI_RDATA = res_val;
                    end else begin
                        axi.M_AXI_RDATA = 32'd0;
                    end
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [31:0] cap_aw, cap_w, cap_ar, p_awaddr, p_wdata, p_araddr;
        bit p_aw, p_w, p_ar, p_rhs;
        cap_aw = '0; cap_w = '0; cap_ar = '0;
        p_awaddr = '0; p_wdata = '0; p_araddr = '0;
        p_aw = 0; p_w = 0; p_ar = 0; p_rhs = 0;
        forever begin
            @(negedge ACLK);
            if (ARESET) begin
                p_aw = 0; p_w = 0; p_ar = 0; p_rhs = 0;
            end else begin
                if (p_aw) begin
                    check("awvalid_hold", 32'(axi.M_AXI_AWVALID), 32'd1);
                    check("awaddr_hold", axi.M_AXI_AWADDR, p_awaddr);
                end
                if (p_w) begin
                    check("wvalid_hold", 32'(axi.M_AXI_WVALID), 32'd1);
                    check("wdata_hold", axi.M_AXI_WDATA, p_wdata);
                end
                if (p_ar) begin
                    check("arvalid_hold", 32'(axi.M_AXI_ARVALID), 32'd1);
                    check("araddr_hold", axi.M_AXI_ARADDR, p_araddr);
                end
                if (p_rhs) check("read_gap", 32'(axi.M_AXI_ARVALID), 32'd0);
                p_aw = axi.M_AXI_AWVALID && !axi.M_AXI_AWREADY;
                p_w  = axi.M_AXI_WVALID && !axi.M_AXI_WREADY;
                p_ar = axi.M_AXI_ARVALID && !axi.M_AXI_ARREADY;
                p_awaddr = axi.M_AXI_AWADDR;
                p_wdata  = axi.M_AXI_WDATA;
                p_araddr = axi.M_AXI_ARADDR;
                p_rhs    = axi.M_AXI_RVALID && axi.M_AXI_RREADY;
                if (axi.M_AXI_AWVALID && axi.M_AXI_AWREADY) begin
                    cap_aw = axi.M_AXI_AWADDR;
                    check("awprot", 32'(axi.M_AXI_AWPROT), 32'd0);
                end
                if (axi.M_AXI_WVALID && axi.M_AXI_WREADY) begin
                    cap_w = axi.M_AXI_WDATA;
                    check("wstrb", 32'(axi.M_AXI_WSTRB), 32'hF);
                end
                if (axi.M_AXI_BVALID && axi.M_AXI_BREADY) got_ev(EV_WR, cap_aw, cap_w);
                if (axi.M_AXI_ARVALID && axi.M_AXI_ARREADY) begin
                    cap_ar = axi.M_AXI_ARADDR;
                    check("arprot", 32'(axi.M_AXI_ARPROT), 32'd0);
                end
                if (axi.M_AXI_RVALID && axi.M_AXI_RREADY) got_ev(EV_RD, cap_ar, 32'd0);
                if (result_valid) got_ev(EV_RES, 32'd0, result);
                if (error) got_ev(EV_ERR, 32'd0, 32'd0);
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic expect_nominal(input logic [31:0] w, input logic [31:0] r);
        push_ev(EV_WR, BASE + 32'h4, w);
        push_ev(EV_WR, BASE, 32'd1);
        for (int i = 0; i < 3; i++) push_ev(EV_RD, BASE + 32'h8, 32'd0);
        push_ev(EV_RD, BASE + 32'hC, 32'd0);
        push_ev(EV_RES, 32'd0, r);
        push_ev(EV_WR, BASE, 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctl"}, {24'd0, busy, result_valid, error, axi.M_AXI_AWVALID,
               axi.M_AXI_WVALID, axi.M_AXI_BREADY, axi.M_AXI_ARVALID, axi.M_AXI_RREADY}, 32'd0);
        check({tag, "_result"}, result, 32'd0);
    endtask

    task automatic run(input string tag, input logic [31:0] w, input bit poke);
        int k;
        start  = 1'b1;
        window = w;
        @(posedge ACLK); #1;
        start = 1'b0;
        check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        if (poke) begin
            repeat (8) @(posedge ACLK);
            #1;
            start  = 1'b1;
            window = 32'h999;
            @(posedge ACLK); #1;
            start = 1'b0;
        end
        k = 0;
        while (busy && k < 3000) begin
            @(posedge ACLK); #1;
            k++;
        end
        check({tag, "_finished_in_time"}, 32'(busy), 32'd0);
        repeat (5) @(posedge ACLK);
        #1;
        check({tag, "_stays_idle"}, 32'(busy), 32'd0);
        check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
        $display("%s done: result=%h", tag, result);
    endtask

    initial begin
        int cnt, k;
        bit prev;
        repeat (3) @(posedge ACLK);
        #1;
        check_outputs_zero("reset");

        // nominal, starting in the first cycle after reset release
        expect_nominal(32'h100, 32'hDEAD_BEEF);
        ARESET = 1'b0;
        run("nominal", 32'h100, 1'b0);
        check("nominal_result", result, 32'hDEAD_BEEF);

        // timeout: done never set, poll limit 4
        done_after = 0;
        push_ev(EV_WR, BASE + 32'h4, 32'h200);
        push_ev(EV_WR, BASE, 32'd1);
        for (int i = 0; i < 4; i++) push_ev(EV_RD, BASE + 32'h8, 32'd0);
        push_ev(EV_ERR, 32'd0, 32'd0);
        push_ev(EV_WR, BASE, 32'd0);
        run("timeout", 32'h200, 1'b0);
        check("timeout_result_kept", result, 32'hDEAD_BEEF);

        // SLVERR on the WINDOW write
        done_after    = 3;
        bresp_err_adr = BASE + 32'h4;
        push_ev(EV_WR, BASE + 32'h4, 32'h300);
        push_ev(EV_ERR, 32'd0, 32'd0);
        push_ev(EV_WR, BASE, 32'd0);
        run("bresp_err", 32'h300, 1'b0);
        check("bresp_err_result_kept", result, 32'hDEAD_BEEF);
        bresp_err_adr = 32'hFFFF_FFFF;

        // reset while the second STATUS read has ARVALID high
        expect_nominal(32'h400, 32'hDEAD_BEEF);
        start  = 1'b1;
        window = 32'h400;
        @(posedge ACLK); #1;
        start = 1'b0;
        cnt = 0; k = 0; prev = 1'b0;
        while (cnt < 2 && k < 500) begin
            if (axi.M_AXI_ARVALID && !prev && axi.M_AXI_ARADDR == BASE + 32'h8) cnt++;
            prev = axi.M_AXI_ARVALID;
            if (cnt < 2) begin
                @(posedge ACLK); #1;
                k++;
            end
        end
        check("reset_found_poll_read", 32'(cnt), 32'd2);
        ARESET = 1'b1;
        exp_q.delete();
        @(posedge ACLK); #1;
        check_outputs_zero("mid_poll_reset");
        ARESET = 1'b0;

        // backpressure run straight after reset, with a start poke while busy
        aw_delay = 3;
        w_delay  = 0;
        stall    = 1'b1;
        expect_nominal(32'h100, 32'hDEAD_BEEF);
        run("backpressure", 32'h100, 1'b1);
        check("backpressure_result", result, 32'hDEAD_BEEF);

        // a second clean run with a different result value
        aw_delay = 0;
        stall    = 1'b0;
        res_val  = 32'h1234_5678;
        expect_nominal(32'h0000_0ABC, 32'h1234_5678);
        run("second", 32'h0000_0ABC, 1'b0);
        check("second_result", result, 32'h1234_5678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
